// File: rtl/dmac_pkg.sv
// Shared definitions for the burst DMA master: FSM state encoding and the
// burst-length selection rule.
package dmac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // Smallest of the words still to move, the longest burst the bus allows and
  // the words left before the next address boundary. Wide operands keep the
  // function independent of the instantiating module's parameters.
  function automatic logic [63:0] burst_len(
    input logic [63:0] remaining,
    input logic [63:0] max_len,
    input logic [63:0] to_boundary
  );
    logic [63:0] m;
    m = (remaining < max_len) ? remaining : max_len;
    return (m < to_boundary) ? m : to_boundary;
  endfunction

endpackage

// File: rtl/dmac_burst_len_calc.sv
// Combinational burst-length calculator: given the current word-aligned
// address offset inside a boundary window and the words remaining, returns
// the number of beats for the next burst.
module dmac_burst_len_calc #(
  parameter int W_BOUNDARY_A   = 12,
  parameter int MAX_BURST_LEN  = 256,
  parameter int W_SIZE         = 32,
  parameter int ADDRMASK_WIDTH = 2,
  parameter int W_LEN          = 9
) (
  input  logic [W_BOUNDARY_A-1:0] addr_low,
  input  logic [W_SIZE-1:0]       remaining,
  output logic [W_LEN-1:0]        len
);
  import dmac_pkg::*;

  logic [63:0] to_boundary;
  logic [63:0] len_full;
  logic        unused_len_hi;

  // Words until the boundary, then the three-way minimum.
  always_comb begin
    to_boundary = ((64'd1 << W_BOUNDARY_A) - 64'(addr_low)) >> ADDRMASK_WIDTH;
    len_full    = burst_len(64'(remaining), 64'(MAX_BURST_LEN), to_boundary);
  end

  // The result never exceeds MAX_BURST_LEN, so the upper bits are always zero.
  assign len           = len_full[W_LEN-1:0];
  assign unused_len_hi = ^len_full[63:W_LEN];

endmodule

// File: rtl/dmac_burst_master.sv
// Burst DMA master: splits a word-count transfer request into AXI-style
// bursts that never cross a 2^W_BOUNDARY_A byte boundary, moving data
// between a local stream and the write (AW/W) or read (AR/R) channels.
module dmac_burst_master #(
  parameter int W_D           = 32,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = 12,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32,
  localparam int ADDRMASK_WIDTH = $clog2(W_D / 8),
  localparam int W_BLEN         = $clog2(MAX_BURST_LEN)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [W_EXT_A-1:0] req_addr,
  input  logic [W_SIZE-1:0]  req_size,
  output logic               awvalid,
  output logic [W_EXT_A-1:0] awaddr,
  output logic [W_BLEN-1:0]  awlen,
  input  logic               awready,
  output logic               wvalid,
  output logic [W_D-1:0]     wdata,
  output logic               wlast,
  input  logic               wready,
  output logic               arvalid,
  output logic [W_EXT_A-1:0] araddr,
  output logic [W_BLEN-1:0]  arlen,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [W_D-1:0]     rdata,
  output logic               rready,
  input  logic               src_valid,
  input  logic [W_D-1:0]     src_data,
  output logic               src_ready,
  output logic               dst_valid,
  output logic [W_D-1:0]     dst_data,
  input  logic               dst_ready
);
  import dmac_pkg::*;

  // Beat counts must hold MAX_BURST_LEN itself, hence one extra bit.
  localparam int W_LEN = W_BLEN + 1;
  localparam logic [W_EXT_A-1:0] ADDR_MASK =
    ~((W_EXT_A'(1) << ADDRMASK_WIDTH) - W_EXT_A'(1));

  state_t             state_reg;
  logic               req_ready_reg;
  logic               awvalid_reg;
  logic               arvalid_reg;
  logic               write_reg;
  logic [W_EXT_A-1:0] addr_reg;
  logic [W_SIZE-1:0]  remaining_reg;
  logic [W_LEN-1:0]   len_reg;
  logic [W_BLEN-1:0]  alen_reg;
  logic [W_LEN-1:0]   beat_cnt_reg;

  logic [W_LEN-1:0]   calc_len;
  logic               data_wr;
  logic               data_rd;
  logic               beat;
  logic               last_beat;

  dmac_burst_len_calc #(
    .W_BOUNDARY_A  (W_BOUNDARY_A),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .W_SIZE        (W_SIZE),
    .ADDRMASK_WIDTH(ADDRMASK_WIDTH),
    .W_LEN         (W_LEN)
  ) u_len_calc (
    .addr_low (addr_reg[W_BOUNDARY_A-1:0]),
    .remaining(remaining_reg),
    .len      (calc_len)
  );

  assign data_wr   = (state_reg == ST_DATA) && write_reg;
  assign data_rd   = (state_reg == ST_DATA) && !write_reg;
  assign beat      = data_wr ? (src_valid && wready) : (data_rd && rvalid && dst_ready);
  assign last_beat = (beat_cnt_reg == len_reg - W_LEN'(1));

  // Request / address / burst sequencing with registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      req_ready_reg <= 1'b1;
      awvalid_reg   <= 1'b0;
      arvalid_reg   <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      len_reg       <= '0;
      alen_reg      <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            write_reg     <= req_write;
            addr_reg      <= req_addr & ADDR_MASK;
            remaining_reg <= req_size;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (remaining_reg == '0) begin
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            len_reg      <= calc_len;
            alen_reg     <= W_BLEN'(calc_len - W_LEN'(1));
            beat_cnt_reg <= '0;
            awvalid_reg  <= write_reg;
            arvalid_reg  <= !write_reg;
            state_reg    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if ((awvalid_reg && awready) || (arvalid_reg && arready)) begin
            awvalid_reg <= 1'b0;
            arvalid_reg <= 1'b0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + W_LEN'(1);
            if (last_beat) begin
              addr_reg      <= addr_reg + (W_EXT_A'(len_reg) << ADDRMASK_WIDTH);
              remaining_reg <= remaining_reg - W_SIZE'(len_reg);
              if (remaining_reg == W_SIZE'(len_reg)) begin
                req_ready_reg <= 1'b1;
                state_reg     <= ST_IDLE;
              end else begin
                state_reg <= ST_CALC;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign awvalid   = awvalid_reg;
  assign arvalid   = arvalid_reg;
  assign awaddr    = addr_reg;
  assign araddr    = addr_reg;
  assign awlen     = alen_reg;
  assign arlen     = alen_reg;

  // Data-phase pass-throughs; every strobe is gated off outside DATA.
  assign wvalid    = data_wr && src_valid;
  assign wdata     = src_data;
  assign wlast     = data_wr && last_beat;
  assign src_ready = data_wr && wready;
  assign dst_valid = data_rd && rvalid;
  assign dst_data  = rdata;
  assign rready    = data_rd && dst_ready;

endmodule

// File: doc/dmac_burst_master.md
DMAC_BURST_MASTER -- requirements
Module: dmac_burst_master
Interface
REQ-001 SHALL have parameter W_D, 32, data width in bits, power of 2 and at least 8; localparam ADDRMASK_WIDTH = log2(W_D/8).
REQ-002 SHALL have parameter W_EXT_A, 32, byte address width.
REQ-003 SHALL have parameter W_BOUNDARY_A, 12, burst boundary of 2^W_BOUNDARY_A bytes.
REQ-004 SHALL have parameter MAX_BURST_LEN, 256, max beats per burst; localparam W_BLEN = log2(MAX_BURST_LEN).
REQ-005 SHALL have parameter W_SIZE, 32, width of the request word count.
REQ-006 SHALL have port CLK  in  1  single clock; one clock, reset synchronous active-high.
REQ-007 SHALL have port RST  in  1  synchronous active-high reset.
REQ-008 SHALL have port req_valid  in  1  transfer request.
REQ-009 SHALL have port req_ready  out  1  idle, accepts request; rises again on completion.
REQ-010 SHALL have port req_write  in  1  1=stream to off-chip (AW/W), 0=off-chip to stream (AR/R).
REQ-011 SHALL have port req_addr  in  W_EXT_A  start byte address.
REQ-012 SHALL have port req_size  in  W_SIZE  transfer length in words.
REQ-013 SHALL have port awvalid  out  1  write address valid.
REQ-014 SHALL have port awaddr  out  W_EXT_A  burst byte address.
REQ-015 SHALL have port awlen  out  W_BLEN  beats-1.
REQ-016 SHALL have port awready  in  1  write address accept.
REQ-017 SHALL have port wvalid  out  1  write beat valid.
REQ-018 SHALL have port wdata  out  W_D  write beat data.
REQ-019 SHALL have port wlast  out  1  last beat of burst.
REQ-020 SHALL have port wready  in  1  write beat accept.
REQ-021 SHALL have port arvalid  out  1  read address valid.
REQ-022 SHALL have port araddr  out  W_EXT_A  burst byte address.
REQ-023 SHALL have port arlen  out  W_BLEN  beats-1.
REQ-024 SHALL have port arready  in  1  read address accept.
REQ-025 SHALL have port rvalid  in  1  read beat valid.
REQ-026 SHALL have port rdata  in  W_D  read beat data.
REQ-027 SHALL have port rready  out  1  read beat accept.
REQ-028 SHALL have port src_valid  in  1  write-data stream valid.
REQ-029 SHALL have port src_data  in  W_D  write-data stream payload.
REQ-030 SHALL have port src_ready  out  1  write-data stream pop.
REQ-031 SHALL have port dst_valid  out  1  read-data stream valid.
REQ-032 SHALL have port dst_data  out  W_D  read-data stream payload.
REQ-033 SHALL have port dst_ready  in  1  read-data stream accept.
Function
REQ-034 SHALL implement FSM IDLE -> CALC -> ADDR -> DATA -> (remaining>0 ? CALC : IDLE); req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, latching direction, addr with low ADDRMASK_WIDTH bits cleared, and size.
REQ-035 SHALL in CALC (1 cycle) set len = min(remaining, MAX_BURST_LEN, words to next 2^W_BOUNDARY_A boundary) and a*len = len-1; remaining==0 in CALC SHALL go straight to IDLE with no bus activity.
REQ-036 SHALL in ADDR hold awvalid (write) or arvalid (read) with stable addr/len until the matching a*ready; valid drops the cycle after the handshake; awvalid and arvalid are never both 1.
REQ-037 SHALL in DATA for writes drive wvalid=src_valid, wdata=src_data, src_ready=wready, with wvalid independent of wready; a beat is wvalid&&wready; wlast=1 on the final beat only.
REQ-038 SHALL in DATA for reads drive dst_valid=rvalid, dst_data=rdata, rready=dst_ready; a beat is rvalid&&rready; the burst ends on the internal beat count; incoming rlast is not used.
REQ-039 SHALL on each burst end advance address by len<<ADDRMASK_WIDTH modulo 2^W_EXT_A and reduce remaining by len; outside DATA, src_ready, rready, wvalid and dst_valid SHALL be 0.
Reset
REQ-040 SHALL on RST force IDLE at the next edge, mid-burst included: req_ready=1; awvalid, arvalid, wvalid, wlast, rready, src_ready, dst_valid=0; counters 0.
Structure
REQ-041 SHALL place FSM state encoding and the burst-length function in shared package dmac_pkg; combinational sub-module dmac_burst_len_calc computes len from addr and remaining.
Verification
REQ-042 SHALL cover: write addr 0x000, size 16 -> one AW (0x000, awlen 15), 16 beats, wlast on beat 16, then req_ready=1.
REQ-043 SHALL cover: write addr 0xFF0, size 8 -> AW (0xFF0, len 3), then AW (0x1000, len 3); no burst crosses 0x1000.
REQ-044 SHALL cover: read addr 0x000, size 300 -> AR (0x000, len 255), then AR (0x400, len 43); 300 dst beats in order.
REQ-045 SHALL cover: size 0 -> req_ready back to 1 within 2 cycles, no awvalid/arvalid.
REQ-046 SHALL cover: random src_valid/dst_ready stalls, then RST asserted mid-burst -> no beat lost or duplicated before reset, and every output at its reset value the cycle after RST.
